// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Receives 8N1 serial frames on rx and turns ASCII command characters into
// the run level and the clear strobe for the downstream up-counter.
//
//   R / r : toggle run
//   S / s : stop (run <= 0)
//   C / c : stop and pulse clear on the same edge
//   other : no control change (byte is still reported)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   rx           in   asynchronous serial input, idles high
//   o_run_on     out  run enable level to the counter
//   o_clr_on     out  one-cycle clear strobe to the counter
//   o_rx_data    out  last correctly framed byte
//   o_rx_valid   out  one-cycle strobe, o_rx_data is new
//   o_frame_err  out  one-cycle strobe, stop bit sampled low
//   o_dbg_state  out  current receiver state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       o_run_on,
    output logic       o_clr_on,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic [1:0] o_dbg_state
);

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // release never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running oversample tick. It is never realigned to the start edge;
    // the resulting 1-tick detection jitter is absorbed by oversampling.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM: state register
    // -----------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [2:0]        bit_idx_q;
    logic [2:0]        bit_idx_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (tick && !rx_sync_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        // Mid start bit: a high line means the low was a glitch.
                        if (!rx_sync_q) begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // LSB arrives first, so shift in from the top.
                        shift_d    = {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Back in IDLE at mid stop bit so a following start
                        // bit with no idle gap is still caught.
                        state_d    = ST_IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Receive FSM: outputs (registered strobes and data)
    // -----------------------------------------------------------------------
    logic       stop_sample;
    logic       rx_valid_q;
    logic       rx_valid_d;
    logic       frame_err_q;
    logic       frame_err_d;
    logic [7:0] rx_data_q;
    logic [7:0] rx_data_d;

    always_comb begin
        stop_sample = (state_q == ST_STOP) && tick && (tick_cnt_q == TICK_LAST);
        rx_valid_d  = stop_sample && rx_sync_q;
        frame_err_d = stop_sample && !rx_sync_q;
        rx_data_d   = rx_data_q;
        if (rx_valid_d) begin
            rx_data_d = shift_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Command decode. Acts one clock after the valid strobe. Clear always
    // forces run low on the same edge, so the counter never sees run and
    // clear together.
    // -----------------------------------------------------------------------
    logic run_q;
    logic run_d;
    logic clr_q;
    logic clr_d;

    always_comb begin
        run_d = run_q;
        clr_d = 1'b0;
        if (rx_valid_q) begin
            case (rx_data_q)
                8'h52, 8'h72: run_d = ~run_q;
                8'h53, 8'h73: run_d = 1'b0;
                8'h43, 8'h63: begin
                    run_d = 1'b0;
                    clr_d = 1'b1;
                end
                default: run_d = run_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            run_q <= run_d;
            clr_q <= clr_d;
        end
    end

    assign o_run_on    = run_q;
    assign o_clr_on    = clr_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_frame_err = frame_err_q;
    assign o_dbg_state = state_q;

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

UART receive and command-decode stage that sits directly upstream of the up-counter. It samples a serial 8N1 line, assembles bytes, and turns ASCII command characters into the counter's run level (`o_run_on`) and one-cycle clear pulse (`o_clr_on`). It also exports each received byte and a framing-error strobe for debug.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: serial bit rate.
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and at least 8.
- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `o_run_on`, out, 1: run enable level to the counter.
- `o_clr_on`, out, 1: one-cycle clear strobe to the counter.
- `o_rx_data`, out, 8: last correctly framed byte.
- `o_rx_valid`, out, 1: one-cycle strobe; `o_rx_data` is new.
- `o_frame_err`, out, 1: one-cycle strobe; the stop bit sampled low.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer, reset value 1. All logic below uses the synchronized signal.
- **Tick generator:** a free-running divider with DIV = floor(CLK_FREQ/(BAUD*OVERSAMPLE)), counting 0..DIV-1. It emits a 1-clk `tick` at DIV-1 and is never realigned to frames.
- **RX FSM** (tick_cnt counts ticks within a bit; bit_idx runs 0..7):
  - IDLE: when synchronized rx is 0 at a tick, go to START with tick_cnt=0.
  - START: at tick_cnt = OVERSAMPLE/2-1 (mid start bit), sample the line.
    - Sample 0: go to DATA with tick_cnt=0, bit_idx=0.
    - Sample 1: treat it as a glitch and return to IDLE with no strobe.
  - DATA: every OVERSAMPLE ticks, sample the line into the shift register, LSB first.
    - After bit_idx=7 is sampled, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample the line.
    - Sample 1: load `o_rx_data` and pulse `o_rx_valid`.
    - Sample 0: pulse `o_frame_err`, leave `o_rx_data` unchanged, and decode no command.
    - In both cases, return to IDLE.
- **Command decode:** acts only on the cycle `o_rx_valid`=1.
  - 0x52 'R' / 0x72 'r': toggle run.
  - 0x53 'S' / 0x73 's': run <= 0.
  - 0x43 'C' / 0x63 'c': run <= 0 and `o_clr_on` pulses on the same edge. The counter therefore sees run=0 and clr=1 together and clears.
  - Any other byte: no control change; `o_rx_valid` still pulses.
- **Reset** (any time, including mid-frame): FSM returns to IDLE and all registers clear. A frame that was in flight is discarded silently.

## Timing
- Reset values: `o_run_on`=0, `o_clr_on`=0, `o_rx_data`=0x00, `o_rx_valid`=0, `o_frame_err`=0.
- `o_rx_valid` or `o_frame_err` rises on the clk edge that follows the STOP-sample tick. Each is high for exactly 1 clk.
- `o_run_on` and `o_clr_on` update on the edge after `o_rx_valid` is high. Latency from the valid strobe is 1 clk.
- `o_clr_on` is never high for more than 1 clk. It never coincides with `o_run_on`=1 as seen by the counter.
- Start-edge detection jitter is at most 1 tick, because the divider is free-running. The resulting bit-centre error is at most 1/OVERSAMPLE bit.
- Back-to-back frames are supported: a start bit immediately after a stop bit is accepted, since the FSM is in IDLE by the next tick.
- The line needs no idle time between frames.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16. This gives DIV=10, so 1 bit = 160 clk.

1. After reset, send 0x72 -> `o_rx_valid` 1-clk pulse with `o_rx_data`=0x72; `o_run_on` goes 0->1 one clk later; `o_clr_on` stays 0.
2. Send 0x52, then 0x41 -> `o_run_on` goes 1->0; the 0x41 frame pulses `o_rx_valid` with data 0x41 and leaves run at 0.
3. With run=1, send 0x63 -> on the same edge, `o_run_on`=0 and `o_clr_on`=1 for exactly 1 clk. Then send 0x43 with run=0 -> clr pulses and run stays 0.
4. Send 0x72 with the stop bit driven 0 -> `o_frame_err` 1-clk pulse, no `o_rx_valid`, `o_run_on` and `o_rx_data` unchanged. A following good 0x73 frame is received normally.
5. Drive rx low for 40 clk (4 ticks) then high -> no `o_rx_valid`, no `o_frame_err`, FSM back in IDLE. A following 0x72 frame is received correctly.
6. Assert reset during bit 4 of a frame -> all outputs 0 and no strobe. After release, a full 0x52 frame gives `o_rx_valid` with data 0x52 and `o_run_on`=1.
